// File: rtl/discretizador_bcd_histerese.sv
// discretizador_bcd_histerese
// Converts a DIGITS-digit BCD reading to binary and maps it to one of LEVELS
// equal-width categories. Hysteresis around each boundary and an N-sample
// confirmation filter suppress chatter from noisy sensor readings.
//   Stage 1: BCD -> binary and digit validity check.
//   Stage 2: hysteresis target computation and confirmation FSM.
// Optional feature macro: DISCRETIZADOR_CONTADOR_EN (saturating change counter).
// Handshake: load is a one-cycle strobe with no back-pressure. bits_in is
// sampled on every rising edge where load is high, and load may be high on
// consecutive cycles. Results come out two edges later.
module discretizador_bcd_histerese #(
  parameter int DIGITS  = 3,
  parameter int LEVELS  = 4,
  parameter int STEP    = 8,
  parameter int HYST    = 2,
  parameter int CONFIRM = 3,
  localparam int OUT_W  = (LEVELS <= 2) ? 1 : $clog2(LEVELS),
  localparam int POW    = 10 ** DIGITS,
  localparam int VAL_W  = $clog2(POW)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] bits_in,
  output logic [OUT_W-1:0]    saida,
  output logic                mudou,
  output logic                erro_bcd,
  output logic [15:0]         conta_mudancas,
  output logic                estado_dbg
);

  typedef enum logic [0:0] {
    ESTAVEL     = 1'b0,
    CONFIRMANDO = 1'b1
  } estado_t;

  // Stage 1 registers
  logic             amostra_q, amostra_d;
  logic [VAL_W-1:0] valor_q, valor_d;
  logic             erro_q, erro_d;

  // Stage 2 registers
  estado_t          estado_q, estado_d;
  logic [OUT_W-1:0] saida_q, saida_d;
  logic [OUT_W-1:0] pend_q, pend_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             mudou_q, mudou_d;

  logic [31:0]      acc;
  logic [3:0]       nib;
  logic             bad;
  logic [31:0]      val_ext, v_menos, v_mais, cur_ext;
  logic [OUT_W-1:0] target;

  // Number of boundaries strictly below v gives its base category.
  function automatic logic [OUT_W-1:0] cat_of(input logic [31:0] v);
    logic [OUT_W-1:0] c;
    c = '0;
    for (int k = 1; k < LEVELS; k++) begin
      if (v > 32'(k * STEP)) c = c + OUT_W'(1);
    end
    return c;
  endfunction

  // Stage 1: BCD to binary, most significant digit first, and nibble check.
  always_comb begin
    acc = '0;
    bad = 1'b0;
    nib = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = bits_in[4*i +: 4];
      if (nib > 4'd9) bad = 1'b1;
      acc = acc * 32'd10 + {28'd0, nib};
    end
    amostra_d = load & ~bad;
    erro_d    = load & bad;
    valor_d   = (load && !bad) ? acc[VAL_W-1:0] : valor_q;
  end

  // Stage 2a: hysteresis target relative to the current confirmed category.
  always_comb begin
    val_ext = 32'(valor_q);
    cur_ext = 32'(saida_q);
    v_menos = (val_ext > 32'(HYST)) ? (val_ext - 32'(HYST)) : 32'd0;
    v_mais  = val_ext + 32'(HYST);
    target  = saida_q;
    if ((saida_q != OUT_W'(LEVELS - 1)) && (v_menos > (cur_ext + 32'd1) * 32'(STEP)))
      target = cat_of(v_menos);
    else if ((saida_q != '0) && (v_mais <= cur_ext * 32'(STEP)))
      target = cat_of(v_mais);
  end

  // Stage 2b: confirmation FSM; only valid samples advance it.
  always_comb begin
    estado_d = estado_q;
    saida_d  = saida_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    mudou_d  = 1'b0;
    if (amostra_q) begin
      case (estado_q)
        ESTAVEL: begin
          if (target != saida_q) begin
            pend_d = target;
            cnt_d  = 4'd1;
            if (CONFIRM == 1) begin
              saida_d = target;
              mudou_d = 1'b1;
            end else begin
              estado_d = CONFIRMANDO;
            end
          end
        end
        CONFIRMANDO: begin
          if (target == saida_q) begin
            estado_d = ESTAVEL;
            cnt_d    = 4'd0;
          end else if (target != pend_q) begin
            pend_d = target;
            cnt_d  = 4'd1;
          end else if (cnt_q + 4'd1 == 4'(CONFIRM)) begin
            saida_d  = pend_q;
            mudou_d  = 1'b1;
            estado_d = ESTAVEL;
            cnt_d    = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: estado_d = ESTAVEL;
      endcase
    end
  end

  // Pipeline and FSM state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      amostra_q <= 1'b0;
      valor_q   <= '0;
      erro_q    <= 1'b0;
      estado_q  <= ESTAVEL;
      saida_q   <= '0;
      pend_q    <= '0;
      cnt_q     <= 4'd0;
      mudou_q   <= 1'b0;
    end else begin
      amostra_q <= amostra_d;
      valor_q   <= valor_d;
      erro_q    <= erro_d;
      estado_q  <= estado_d;
      saida_q   <= saida_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      mudou_q   <= mudou_d;
    end
  end

  assign saida      = saida_q;
  assign mudou      = mudou_q;
  assign erro_bcd   = erro_q;
  assign estado_dbg = (estado_q == CONFIRMANDO);

`ifdef DISCRETIZADOR_CONTADOR_EN
  logic [15:0] conta_q, conta_d;

  // Saturating count of confirmed category changes.
  always_comb begin
    conta_d = conta_q;
    if (mudou_q && (conta_q != 16'hFFFF)) conta_d = conta_q + 16'd1;
  end

  // Change counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) conta_q <= 16'h0000;
    else          conta_q <= conta_d;
  end

  assign conta_mudancas = conta_q;
`else
  assign conta_mudancas = 16'h0000;
`endif

endmodule
